// File: rtl/mos_switch_bank_pkg.sv
// Shared types and switch-level helper functions for the MOS switch bank.
// Four-state values are carried as 2-bit codes: 00=0, 01=1, 10=Z, 11=X.
// resolve2 is used only when the design is built with MOS_RESOLVE_EN.
package mos_pkg;

  typedef logic [1:0] logic4_t;

  localparam logic4_t L0 = 2'b00;
  localparam logic4_t L1 = 2'b01;
  localparam logic4_t LZ = 2'b10;
  localparam logic4_t LX = 2'b11;

  // Effective gate seen by the channel: pmos conducts on a low gate, so 0/1
  // swap; an undriven or unknown pmos gate is unknown either way.
  function automatic logic4_t eff_gate(input logic is_pmos, input logic4_t ctrl);
    logic4_t g;
    g = ctrl;
    if (is_pmos) begin
      case (ctrl)
        L0:      g = L1;
        L1:      g = L0;
        default: g = LX;
      endcase
    end
    return g;
  endfunction

  // Value presented at the drain for a given effective gate and source.
  // With an unknown gate a floating source still floats; a driven source
  // may or may not pass, so it becomes X.
  function automatic logic4_t switch_target(input logic4_t gate, input logic4_t data);
    logic4_t t;
    case (gate)
      L1:      t = data;
      L0:      t = LZ;
      default: t = (data == LZ) ? LZ : LX;
    endcase
    return t;
  endfunction

  // Wired resolution of two drivers: Z yields to anything, conflicting or
  // unknown drivers give X.
  function automatic logic4_t resolve2(input logic4_t a, input logic4_t b);
    logic4_t r;
    if (a == LZ)                   r = b;
    else if (b == LZ)              r = a;
    else if (a == LX || b == LX)   r = LX;
    else if (a == b)               r = a;
    else                           r = LX;
    return r;
  endfunction

endpackage

// File: rtl/mos_switch_bank_if.sv
// Bundle of the switch bank's terminal signals. The bank is the slave
// (it receives gate/source values and drives the drains); the environment
// is the master. The node signal exists only under MOS_RESOLVE_EN.
interface mos_switch_bank_if
  import mos_pkg::*;
#(
  parameter int N = 8
);

  logic [N-1:0]   is_pmos;
  logic [2*N-1:0] data_in;
  logic [2*N-1:0] ctrl_in;
  logic [2*N-1:0] out;
`ifdef MOS_RESOLVE_EN
  logic4_t        node;

  modport master (output is_pmos, data_in, ctrl_in, input out, node);
  modport slave  (input is_pmos, data_in, ctrl_in, output out, node);
`else
  modport master (output is_pmos, data_in, ctrl_in, input out);
  modport slave  (input is_pmos, data_in, ctrl_in, output out);
`endif

endinterface

// File: rtl/mos_switch_bank_chan.sv
// One MOS switch channel: computes the drain target from gate and source,
// picks the edge delay for that target, and applies it inertially so that
// only targets held steady for the full delay reach the registered output.
module mos_switch_chan
  import mos_pkg::*;
#(
  parameter int RISE_DLY = 1,
  parameter int FALL_DLY = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    is_pmos,
  input  logic4_t data,
  input  logic4_t ctrl,
  output logic4_t out
);

  localparam int MAX_DLY = (RISE_DLY > FALL_DLY) ? RISE_DLY : FALL_DLY;
  localparam int MIN_DLY = (RISE_DLY < FALL_DLY) ? RISE_DLY : FALL_DLY;
  localparam int CW      = (MAX_DLY > 0) ? $clog2(MAX_DLY + 1) : 1;

  logic4_t       target;
  logic [CW-1:0] dly;

  logic4_t       out_reg,  out_next;
  logic          pend_reg, pend_next;
  logic4_t       pval_reg, pval_next;
  logic [CW-1:0] cnt_reg,  cnt_next;

  // Drain target and the delay that applies to reaching it.
  always_comb begin
    target = switch_target(eff_gate(is_pmos, ctrl), data);
    case (target)
      L1:      dly = CW'(RISE_DLY);
      L0:      dly = CW'(FALL_DLY);
      default: dly = CW'(MIN_DLY);
    endcase
  end

  // Inertial delay: cnt counts edges at which the pending target has been
  // seen; the output commits when that count reaches the delay.
  always_comb begin
    out_next  = out_reg;
    pend_next = pend_reg;
    pval_next = pval_reg;
    cnt_next  = cnt_reg;
    if (target == out_reg) begin
      pend_next = 1'b0;
      cnt_next  = '0;
    end else if (!pend_reg || target != pval_reg) begin
      if (dly == '0) begin
        out_next  = target;
        pend_next = 1'b0;
        cnt_next  = '0;
      end else begin
        pend_next = 1'b1;
        pval_next = target;
        cnt_next  = CW'(1);
      end
    end else if (cnt_reg == dly) begin
      out_next  = pval_reg;
      pend_next = 1'b0;
      cnt_next  = '0;
    end else begin
      cnt_next = cnt_reg + CW'(1);
    end
  end

  // State registers; reset floats the drain and drops any pending update.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg  <= LZ;
      pend_reg <= 1'b0;
      pval_reg <= LZ;
      cnt_reg  <= '0;
    end else begin
      out_reg  <= out_next;
      pend_reg <= pend_next;
      pval_reg <= pval_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign out = out_reg;

endmodule

// File: rtl/mos_switch_bank.sv
// Bank of N independent MOS pass switches with per-edge inertial delays.
// Optional macro MOS_RESOLVE_EN adds a registered wired-resolution node
// driven by all channel outputs, one cycle behind them.
module mos_switch_bank
  import mos_pkg::*;
#(
  parameter int N        = 8,
  parameter int RISE_DLY = 1,
  parameter int FALL_DLY = 1
) (
  input logic              clk,
  input logic              rst,
  mos_switch_bank_if.slave bus
);

  logic [2*N-1:0] out_vec;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      mos_switch_chan #(
        .RISE_DLY (RISE_DLY),
        .FALL_DLY (FALL_DLY)
      ) u_chan (
        .clk     (clk),
        .rst     (rst),
        .is_pmos (bus.is_pmos[gi]),
        .data    (bus.data_in[2*gi +: 2]),
        .ctrl    (bus.ctrl_in[2*gi +: 2]),
        .out     (out_vec[2*gi +: 2])
      );
    end
  endgenerate

  assign bus.out = out_vec;

`ifdef MOS_RESOLVE_EN
  logic4_t node_reg, node_next;

  // Fold every channel output into one wired value.
  always_comb begin
    node_next = LZ;
    for (int i = 0; i < N; i++) begin
      node_next = resolve2(node_next, out_vec[2*i +: 2]);
    end
  end

  // Register the resolved node; it floats out of reset.
  always_ff @(posedge clk) begin
    if (rst) node_reg <= LZ;
    else     node_reg <= node_next;
  end

  assign bus.node = node_reg;
`endif

endmodule

// File: tb/tb_mos_switch_bank.sv
// Self-checking bench for mos_switch_bank. Three instances with different
// delay settings share one stimulus; directed scenarios check hand-derived
// values and a randomized run checks a run-length reference model.
// Build with MOS_RESOLVE_EN to also check the wired node.
module tb_mos_switch_bank;

  localparam int N  = 8;
  localparam int NU = 3;
  localparam logic [1:0] V0 = 2'b00, V1 = 2'b01, VZ = 2'b10, VX = 2'b11;

  // Instance u: 0 -> rise 2/fall 1, 1 -> rise 3/fall 1, 2 -> zero delay
  int rise_d [NU] = '{2, 3, 0};
  int fall_d [NU] = '{1, 1, 0};

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   is_pmos;
  logic [2*N-1:0] data_in, ctrl_in;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mos_switch_bank_if #(.N(N)) if_a ();
  mos_switch_bank_if #(.N(N)) if_b ();
  mos_switch_bank_if #(.N(N)) if_c ();

  assign if_a.is_pmos = is_pmos; assign if_a.data_in = data_in; assign if_a.ctrl_in = ctrl_in;
  assign if_b.is_pmos = is_pmos; assign if_b.data_in = data_in; assign if_b.ctrl_in = ctrl_in;
  assign if_c.is_pmos = is_pmos; assign if_c.data_in = data_in; assign if_c.ctrl_in = ctrl_in;

  mos_switch_bank #(.N(N), .RISE_DLY(2), .FALL_DLY(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  mos_switch_bank #(.N(N), .RISE_DLY(3), .FALL_DLY(1)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  mos_switch_bank #(.N(N), .RISE_DLY(0), .FALL_DLY(0)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

  logic [2*N-1:0] dut_out [NU];
  assign dut_out[0] = if_a.out;
  assign dut_out[1] = if_b.out;
  assign dut_out[2] = if_c.out;
`ifdef MOS_RESOLVE_EN
  logic [1:0] dut_node [NU];
  assign dut_node[0] = if_a.node;
  assign dut_node[1] = if_b.node;
  assign dut_node[2] = if_c.node;
`endif

  // ---------------- reference model ----------------
  // A channel's output adopts a target once that target has been observed
  // on (delay+1) consecutive edges while differing from the output.
  logic [1:0] m_out  [NU][N];
  logic [1:0] m_last [NU][N];
  int         m_run  [NU][N];
  logic [1:0] m_node [NU];

  function automatic logic [1:0] ref_target(input logic pm, input logic [1:0] d, input logic [1:0] c);
    logic on, off;
    on  = pm ? (c == V0) : (c == V1);
    off = pm ? (c == V1) : (c == V0);
    if (on)       return d;
    if (off)      return VZ;
    if (d == VZ)  return VZ;
    return VX;
  endfunction

  function automatic int ref_dly(input int u, input logic [1:0] t);
    if (t == V1) return rise_d[u];
    if (t == V0) return fall_d[u];
    return (rise_d[u] < fall_d[u]) ? rise_d[u] : fall_d[u];
  endfunction

  function automatic logic [1:0] ref_resolve(input int u);
    bit has0, has1, hasx;
    has0 = 0; has1 = 0; hasx = 0;
    for (int i = 0; i < N; i++) begin
      if (m_out[u][i] == V0) has0 = 1;
      if (m_out[u][i] == V1) has1 = 1;
      if (m_out[u][i] == VX) hasx = 1;
    end
    if (hasx || (has0 && has1)) return VX;
    if (has0) return V0;
    if (has1) return V1;
    return VZ;
  endfunction

  task automatic model_update();
    logic [1:0] t, nd;
    for (int u = 0; u < NU; u++) begin
      nd = ref_resolve(u);
      for (int i = 0; i < N; i++) begin
        if (rst) begin
          m_out[u][i] = VZ;
          m_run[u][i] = 0;
          m_last[u][i] = VZ;
        end else begin
          t = ref_target(is_pmos[i], data_in[2*i +: 2], ctrl_in[2*i +: 2]);
          if (m_run[u][i] > 0 && t == m_last[u][i]) m_run[u][i]++;
          else m_run[u][i] = 1;
          m_last[u][i] = t;
          if (t != m_out[u][i] && m_run[u][i] >= ref_dly(u, t) + 1) m_out[u][i] = t;
        end
      end
      m_node[u] = rst ? VZ : nd;
    end
  endtask

  function automatic logic [2*N-1:0] model_vec(input int u);
    logic [2*N-1:0] v;
    for (int i = 0; i < N; i++) v[2*i +: 2] = m_out[u][i];
    return v;
  endfunction

  // One clock edge: DUTs and model both sample, outputs read at the negedge.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_ch(input int i, input logic pm, input logic [1:0] d, input logic [1:0] c);
    is_pmos[i]         = pm;
    data_in[2*i +: 2]  = d;
    ctrl_in[2*i +: 2]  = c;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    is_pmos = N'($urandom); data_in = 16'($urandom); ctrl_in = 16'($urandom);
    rst = 1'b1;
    tick(); tick();
    for (int u = 0; u < NU; u++) begin
      n_cmp++;
      if (dut_out[u] !== {N{VZ}}) begin
        n_err++; $display("FAIL reset_out u%0d got=%h exp=%h", u, dut_out[u], {N{VZ}});
      end else $display("reset_out u%0d out=%h", u, dut_out[u]);
`ifdef MOS_RESOLVE_EN
      n_cmp++;
      if (dut_node[u] !== VZ) begin
        n_err++; $display("FAIL reset_node u%0d got=%b exp=%b", u, dut_node[u], VZ);
      end
`endif
    end
    rst = 1'b0;
  endtask

  // Instance 0 (rise 2, fall 1), channel 0 nmos with data 1.
  task automatic test_nmos_delay();
    logic [1:0] exp_seq [7] = '{VZ, VZ, V1, V1, V0, V0, VZ};
    set_ch(0, 1'b0, V1, V0);
    tick(); tick(); tick();
    ctrl_in[1:0] = V1;
    for (int s = 0; s < 7; s++) begin
      if (s == 3) data_in[1:0] = V0;
      if (s == 5) ctrl_in[1:0] = V0;
      tick();
      n_cmp++;
      if (dut_out[0][1:0] !== exp_seq[s]) begin
        n_err++; $display("FAIL nmos_delay step%0d got=%b exp=%b", s, dut_out[0][1:0], exp_seq[s]);
      end else $display("nmos_delay step%0d out=%b", s, dut_out[0][1:0]);
    end
  endtask

  // Instance 0, channel 1 pmos; every delay here is one edge.
  task automatic test_pmos();
    logic [1:0] d_seq [4] = '{V0, V0, V0, VZ};
    logic [1:0] c_seq [4] = '{V0, V1, VZ, VX};
    logic [1:0] e_seq [4] = '{V0, VZ, VX, VZ};
    set_ch(1, 1'b1, V0, V1);
    tick(); tick(); tick();
    for (int s = 0; s < 4; s++) begin
      data_in[3:2] = d_seq[s];
      ctrl_in[3:2] = c_seq[s];
      tick(); tick();
      n_cmp++;
      if (dut_out[0][3:2] !== e_seq[s]) begin
        n_err++; $display("FAIL pmos step%0d got=%b exp=%b", s, dut_out[0][3:2], e_seq[s]);
      end else $display("pmos step%0d out=%b", s, dut_out[0][3:2]);
    end
  endtask

  // Instance 1 (rise 3), channel 2 nmos data 1: short high pulse is filtered.
  task automatic test_glitch();
    logic [1:0] c_seq [8] = '{V1, V1, V0, V0, V1, V1, V1, V1};
    logic [1:0] e_seq [8] = '{VZ, VZ, VZ, VZ, VZ, VZ, VZ, V1};
    set_ch(2, 1'b0, V1, V0);
    tick(); tick(); tick(); tick();
    for (int s = 0; s < 8; s++) begin
      ctrl_in[5:4] = c_seq[s];
      tick();
      n_cmp++;
      if (dut_out[1][5:4] !== e_seq[s]) begin
        n_err++; $display("FAIL glitch step%0d got=%b exp=%b", s, dut_out[1][5:4], e_seq[s]);
      end else $display("glitch step%0d out=%b", s, dut_out[1][5:4]);
    end
  endtask

  // Instance 2 (zero delay): each channel independently passes its own value.
  task automatic test_independence();
    logic [1:0] dv [4] = '{V0, V1, VZ, VX};
    logic [2*N-1:0] exp_v;
    for (int i = 0; i < 4; i++) set_ch(i, 1'b0, dv[i], V1);
    for (int i = 4; i < N; i++) set_ch(i, 1'b1, 2'($urandom), V1);
    tick();
    exp_v = {VZ, VZ, VZ, VZ, VX, VZ, V1, V0};
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (dut_out[2][2*i +: 2] !== exp_v[2*i +: 2]) begin
        n_err++; $display("FAIL indep ch%0d got=%b exp=%b", i, dut_out[2][2*i +: 2], exp_v[2*i +: 2]);
      end else $display("indep ch%0d out=%b", i, dut_out[2][2*i +: 2]);
    end
  endtask

`ifdef MOS_RESOLVE_EN
  // Instance 2: CMOS inverter from a pmos pull-up and nmos pull-down.
  task automatic test_inverter();
    logic [1:0] in_seq [3] = '{V0, V1, VX};
    logic [1:0] e_seq  [3] = '{V1, V0, VX};
    logic [1:0] prev;
    for (int i = 2; i < N; i++) set_ch(i, 1'b0, 2'($urandom), V0);
    set_ch(0, 1'b1, V1, V0);
    set_ch(1, 1'b0, V0, V0);
    tick(); tick();
    prev = V1;
    for (int s = 0; s < 3; s++) begin
      ctrl_in[1:0] = in_seq[s];
      ctrl_in[3:2] = in_seq[s];
      tick();
      n_cmp++;
      if (dut_node[2] !== prev) begin
        n_err++; $display("FAIL inv_lag step%0d got=%b exp=%b", s, dut_node[2], prev);
      end
      tick();
      n_cmp++;
      if (dut_node[2] !== e_seq[s]) begin
        n_err++; $display("FAIL inv_node step%0d got=%b exp=%b", s, dut_node[2], e_seq[s]);
      end else $display("inv step%0d in=%b node=%b", s, in_seq[s], dut_node[2]);
      prev = e_seq[s];
    end
  endtask
`endif

  // Sparse random changes so that delays have a chance to complete.
  task automatic test_random();
    int errs;
    for (int s = 0; s < 150; s++) begin
      rst = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 2) == 0) set_ch(i, 1'($urandom), 2'($urandom), 2'($urandom));
      tick();
      errs = 0;
      for (int u = 0; u < NU; u++) begin
        n_cmp++;
        if (dut_out[u] !== model_vec(u)) begin
          n_err++; errs++;
          $display("FAIL random_out step%0d u%0d got=%h exp=%h", s, u, dut_out[u], model_vec(u));
        end
`ifdef MOS_RESOLVE_EN
        n_cmp++;
        if (dut_node[u] !== m_node[u]) begin
          n_err++; errs++;
          $display("FAIL random_node step%0d u%0d got=%b exp=%b", s, u, dut_node[u], m_node[u]);
        end
`endif
      end
      $display("random step%0d rst=%0b errors=%0d", s, rst, errs);
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int u = 0; u < NU; u++) begin
      for (int i = 0; i < N; i++) begin
        m_out[u][i] = VZ; m_last[u][i] = VZ; m_run[u][i] = 0;
      end
      m_node[u] = VZ;
    end
    rst = 1'b1; is_pmos = '0; data_in = '0; ctrl_in = '0;
    @(negedge clk);
    test_reset();
    test_nmos_delay();
    test_pmos();
    test_glitch();
    test_independence();
`ifdef MOS_RESOLVE_EN
    test_inverter();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
